logic_result_stage: RTL and testbench
=====================================

# logic_result_stage

Pipeline register stage directly downstream of the 32-bit bitwise logic units (AND/OR/XOR/NOR) in the ALU. It selects one unit's result by opcode, derives status flags, and holds the result behind a valid/ready handshake. A 2-entry skid buffer absorbs back-pressure from the writeback stage without creating a combinational ready path.

## Interface
- `WIDTH`, 32, datapath width; flags are defined for any `WIDTH` ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low; one clock domain.
- `in_valid`  in  1  upstream result valid.
- `in_ready`  out  1  stage can accept (registered).
- `op`  in  2  select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- `and_in`, `or_in`, `xor_in`, `nor_in`  in  WIDTH each  logic unit outputs.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `result`  out  WIDTH  selected result.
- `flag_z`  out  1  result == 0.
- `flag_n`  out  1  result[WIDTH-1].
- `flag_p`  out  1  XOR-reduce of result (1 = odd popcount); only with `LRS_PARITY_EN`, otherwise tied 0.

## Operation
- Input transfer when `in_valid && in_ready`; output transfer when `out_valid && out_ready`.
- Mux by `op`; flags computed on the muxed value at input, stored with the entry: {result, z, n, p}.
- Storage: main register (drives outputs) plus one skid register.
- FSM, states EMPTY / ONE / TWO:
  - EMPTY: input xfer → ONE (load main).
  - ONE: input only → TWO (load skid); output only → EMPTY; both → ONE (main reloaded with new entry); neither → hold.
  - TWO: output xfer → ONE (skid moves to main); input cannot occur (`in_ready`=0).
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO; it is registered, so it depends only on state.
- `out_valid` = 1 in ONE and TWO.
- Outputs stay stable while `out_valid && !out_ready`. Order is strictly FIFO.
- Reset: state EMPTY, `out_valid`=0, `in_ready`=1 after reset is released, `result`=0, all flags 0; the skid register is cleared. Asserting reset mid-transfer discards all entries immediately (asynchronous).

## Timing
- Latency: input accepted at edge k → `out_valid` and data visible after edge k (usable in cycle k+1).
- Throughput: 1 result/cycle while `out_ready` stays high.
- `in_ready` falls the cycle after entering TWO. It rises the cycle after the output transfer that leaves TWO.
- There is no combinational path from `out_ready` to `in_ready`, or from any input to any output.

## Configuration
- `LRS_PARITY_EN` defined: a parity bit is stored per entry and `flag_p` is driven.
- Not defined: no parity storage or logic, and `flag_p` is constant 0.
- Z/N behaviour is identical in both builds.

## Structure
- Shared package `alu_logic_pkg`: opcode constants `LOP_AND`=2'b00, `LOP_OR`=2'b01, `LOP_XOR`=2'b10, `LOP_NOR`=2'b11; FSM state enum; entry struct {result, z, n, p}.
- One sub-module, `logic_flag_gen`: combinational, WIDTH-parameterised, produces z/n/p from a value. The stage instantiates it once, at the input side.

## Test plan
- Reset then single transfer: reset released, `op`=10, `xor_in`=0xF0F00F0F, `out_ready`=1 → next cycle `result`=0xF0F00F0F, z=0, n=1, p=0; `out_valid` drops the following cycle.
- Zero flag: `op`=10, `xor_in`=0x00000000 → z=1, n=0, p=0. With `op`=11 and `nor_in`=0x00000001 → z=0, p=1 (p forced 0 when `LRS_PARITY_EN` is undefined).
- Back-pressure: `out_ready`=0, push 0x11 then 0x22 → `in_ready`=0 after the second push and `result` held at 0x11. Raise `out_ready` → 0x11, then 0x22, in order; `in_ready` returns to 1.
- Streaming: 16 back-to-back inputs cycling through ops 00..11 with `out_ready`=1 → 16 outputs in order, one per cycle, each matching the selected input.
- Simultaneous in/out in ONE: hold 0x33 in main, then present 0x44 with `out_ready`=1 in the same cycle → 0x33 consumed, 0x44 shown next cycle, state stays ONE.
- Async reset mid-operation in TWO: assert `rst_n`=0 between edges → `out_valid`=0 and `result`=0 immediately; after release the stage is empty and `in_ready`=1.

Source files
------------

// File: rtl/alu_logic_pkg.sv
// Shared types for the ALU logic-result path: opcodes, stage FSM states, per-entry flags.
// The parity flag field exists only when LRS_PARITY_EN is defined.
package alu_logic_pkg;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } lrs_state_e;

    // Flags travel with each stored result; an entry is {result, z, n, p}.
    typedef struct packed {
        logic z;
        logic n;
`ifdef LRS_PARITY_EN
        logic p;
`endif
    } lrs_flags_t;

endpackage

// File: rtl/logic_result_stage_if.sv
// Handshake and data bundle between the logic units, the result stage and writeback.
interface logic_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] and_in;
    logic [WIDTH-1:0] or_in;
    logic [WIDTH-1:0] xor_in;
    logic [WIDTH-1:0] nor_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_p;

    modport master (
        output in_valid, op, and_in, or_in, xor_in, nor_in, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_p
    );

    modport slave (
        input  in_valid, op, and_in, or_in, xor_in, nor_in, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_p
    );
endinterface

// File: rtl/logic_flag_gen.sv
// Combinational status flags (zero, negative, and parity when LRS_PARITY_EN is defined).
module logic_flag_gen
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output lrs_flags_t       flags
);

    assign flags.z = (value == '0);
    assign flags.n = value[WIDTH-1];
`ifdef LRS_PARITY_EN
    assign flags.p = ^value;
`endif

endmodule

// File: rtl/logic_result_stage.sv
// Result-select pipeline stage with a 2-entry skid buffer behind a registered valid/ready.
// Build option LRS_PARITY_EN adds a stored parity bit driving flag_p.
module logic_result_stage
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        lrs_flags_t       flags;
    } entry_t;

    lrs_state_e       state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [WIDTH-1:0] sel_value;
    lrs_flags_t       in_flags;
    entry_t           in_entry;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the signal unassigned (no latch).
        sel_value = bus.and_in;
        case (bus.op)
            LOP_OR:  sel_value = bus.or_in;
            LOP_XOR: sel_value = bus.xor_in;
            LOP_NOR: sel_value = bus.nor_in;
            default: sel_value = bus.and_in;
        endcase
    end

    logic_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .value (sel_value),
        .flags (in_flags)
    );

    assign in_entry = {sel_value, in_flags};
    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    // State register plus storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            // NOTE: the skid entry is reset too, so nothing stale can ever reach the outputs.
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_ONE;
            ST_ONE: begin
                if (in_xfer && !out_xfer)      state_d = ST_TWO;
                else if (out_xfer && !in_xfer) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // in_ready comes only from the state flop, so out_ready never reaches it combinationally.
    always_comb begin
        bus.in_ready  = (state_q != ST_TWO);
        bus.out_valid = (state_q != ST_EMPTY);
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) main_d = in_entry;
            ST_ONE: begin
                if (in_xfer && !out_xfer) skid_d = in_entry;
                else if (in_xfer)         main_d = in_entry;
            end
            ST_TWO:   if (out_xfer) main_d = skid_q;
            default:  ;
        endcase
    end

    assign bus.result = main_q.result;
    assign bus.flag_z = main_q.flags.z;
    assign bus.flag_n = main_q.flags.n;
`ifdef LRS_PARITY_EN
    assign bus.flag_p = main_q.flags.p;
`else
    assign bus.flag_p = 1'b0;
`endif

endmodule

// File: tb/tb_logic_result_stage.sv
// Scoreboard bench for logic_result_stage: reference entries are queued on input transfers
// and compared against the stage outputs on output transfers.
module tb_logic_result_stage;
    import alu_logic_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] result;
        logic         z;
        logic         n;
        logic         p;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_result_stage_if #(.WIDTH(W)) bus ();

    logic_result_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    localparam logic EXP_P_ON_ONE = `ifdef LRS_PARITY_EN 1'b1 `else 1'b0 `endif ;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] n);
        exp_t e;
        case (op)
            LOP_AND: e.result = a;
            LOP_OR:  e.result = o;
            LOP_XOR: e.result = x;
            default: e.result = ~(~n);
        endcase
        e.z = (e.result == '0);
        e.n = e.result[W-1];
`ifdef LRS_PARITY_EN
        e.p = ^e.result;
`else
        e.p = 1'b0;
`endif
        return e;
    endfunction

    // One cycle: record transfers visible now, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        if (bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.op, bus.and_in, bus.or_in, bus.xor_in, bus.nor_in));
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got result=%h with empty scoreboard", bus.result);
            end else begin
                e = sb.pop_front();
                if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got %h z%b n%b p%b, expected %h z%b n%b p%b",
                             bus.result, bus.flag_z, bus.flag_n, bus.flag_p,
                             e.result, e.z, e.n, e.p);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [W-1:0] val);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.and_in   = $urandom;
        bus.or_in    = $urandom;
        bus.xor_in   = $urandom;
        bus.nor_in   = $urandom;
        case (op)
            LOP_AND: bus.and_in = val;
            LOP_OR:  bus.or_in  = val;
            LOP_XOR: bus.xor_in = val;
            default: bus.nor_in = val;
        endcase
    endtask

    task automatic push(input logic [1:0] op, input logic [W-1:0] val);
        drive(op, val);
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=%b, required 1 within 20 cycles", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (bus.out_valid || sb.size() != 0); i++) tick();
        checks++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: out_valid=%b pending=%0d, required 0 and 0", bus.out_valid, sb.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.op        = LOP_AND;
        bus.and_in    = '0;
        bus.or_in     = '0;
        bus.xor_in    = '0;
        bus.nor_in    = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
        end
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== {{W{1'b0}}, 3'b000}) begin
            errors++; $display("FAIL reset_data: got %h flags %b%b%b, required 0 and 000",
                               bus.result, bus.flag_z, bus.flag_n, bus.flag_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_release: in_ready/out_valid=%b, required 10",
                               {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        push(LOP_XOR, 32'hF0F00F0F);
        checks++;
        if ({bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== {1'b1, 32'hF0F00F0F, 3'b010}) begin
            errors++; $display("FAIL single_xfer: got v%b %h z%b n%b p%b, required v1 f0f00f0f z0 n1 p0",
                               bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_p);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drop: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_zero_flag();
        bus.out_ready = 1'b0;
        push(LOP_XOR, 32'h0);
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== {32'h0, 3'b100}) begin
            errors++; $display("FAIL zero_flag: got %h z%b n%b p%b, required 0 z1 n0 p0",
                               bus.result, bus.flag_z, bus.flag_n, bus.flag_p);
        end
        bus.out_ready = 1'b1;
        push(LOP_NOR, 32'h1);
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== {32'h1, 2'b00, EXP_P_ON_ONE}) begin
            errors++; $display("FAIL parity_flag: got %h z%b n%b p%b, required 1 z0 n0 p%b",
                               bus.result, bus.flag_z, bus.flag_n, bus.flag_p, EXP_P_ON_ONE);
        end
        drain();
    endtask

    task automatic test_back_pressure();
        bus.out_ready = 1'b0;
        push(LOP_AND, 32'h11);
        push(LOP_AND, 32'h22);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.result} !== {2'b01, 32'h11}) begin
                errors++; $display("FAIL bp_hold: in_ready=%b out_valid=%b result=%h, required 0 1 00000011",
                                   bus.in_ready, bus.out_valid, bus.result);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if ({bus.in_ready, bus.result} !== {1'b1, 32'h22}) begin
            errors++; $display("FAIL bp_release: in_ready=%b result=%h, required 1 00000022",
                               bus.in_ready, bus.result);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            drive(2'(i % 4), $urandom);
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d]: in_ready=%b, required 1", i, bus.in_ready);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pops != 15) begin
            errors++; $display("FAIL stream_rate: %0d outputs during 16 input cycles, required 15", pops);
        end
        drain();
        checks++;
        if (pops != 16) begin
            errors++; $display("FAIL stream_count: %0d outputs total, required 16", pops);
        end
    endtask

    task automatic test_simultaneous();
        bus.out_ready = 1'b0;
        push(LOP_OR, 32'h33);
        bus.out_ready = 1'b1;
        drive(LOP_AND, 32'h44);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.result} !== {2'b11, 32'h44}) begin
            errors++; $display("FAIL simul_one: in_ready=%b out_valid=%b result=%h, required 1 1 00000044",
                               bus.in_ready, bus.out_valid, bus.result);
        end
        drain();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        push(LOP_AND, 32'h55);
        push(LOP_OR, 32'h66);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL areset_full: in_ready=%b, required 0", bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_p} !== {1'b0, {W{1'b0}}, 3'b000}) begin
            errors++; $display("FAIL areset_now: out_valid=%b result=%h flags %b%b%b, required 0 0 000",
                               bus.out_valid, bus.result, bus.flag_z, bus.flag_n, bus.flag_p);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++; $display("FAIL areset_release: in_ready/out_valid=%b, required 10",
                               {bus.in_ready, bus.out_valid});
        end
        push(LOP_XOR, 32'h77);
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_flag();
        test_back_pressure();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
